// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types and helpers for the round-robin RAM arbiter.
//            id_width() : channel-id width for a channel count (min 1 bit).
//            arb_req_t  : one channel request (we, addr, wdata, wstrb), sized
//                         for the widest supported configuration. Users fill
//                         the low bits and leave the upper bits zero.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  localparam int unsigned REQ_AW_MAX = 64;
  localparam int unsigned REQ_DW_MAX = 1024;

  typedef struct packed {
    logic                    we;
    logic [REQ_AW_MAX-1:0]   addr;
    logic [REQ_DW_MAX-1:0]   wdata;
    logic [REQ_DW_MAX/8-1:0] wstrb;
  } arb_req_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin grant over NCH requesters. The search starts at the
//            internal pointer; the first requesting channel wins and the
//            pointer moves to the channel after the winner. With no request
//            the pointer holds.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            req_i          - per-channel request
//            gnt_o          - one-hot grant (combinational)
//            gnt_id_o       - index of the granted channel
//            gnt_any_o      - a grant is issued this cycle
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int  NCH = 4,
  localparam int IDW = id_width(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           gnt_any_o
);

  logic [IDW-1:0] ptr_q, ptr_d;

  // Walk the channels in rotation order starting at ptr_q.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_any_o = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_any_o && req_i[idx]) begin
        gnt_any_o     = 1'b1;
        gnt_o[idx]    = 1'b1;
        gnt_id_o      = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = (int'(gnt_id_o) == NCH - 1) ? '0 : gnt_id_o + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_rr_arbiter
// Purpose  : Shares one single-port RAM between NCH channels. One request is
//            accepted per cycle (round-robin, reads and writes alike), issued
//            to the RAM on the following cycle, and read responses are routed
//            back to the requesting channel RD_LAT cycles after the read.
// Ports    : clk, rst                 - clock, asynchronous active-high reset
//            req_valid/req_ready      - per-channel request handshake
//            req_we/addr/wdata/wstrb  - per-channel request payload (flat)
//            rsp_valid, rsp_data      - one-hot response valid, shared data
//            ren/raddr/rdata          - RAM read port
//            wen/waddr/wdata/wstrb    - RAM write port
// Revision : 1.0 - initial release
// ============================================================================
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int  NCH            = 4,
  parameter int  AXI_WIDTH      = 128,
  parameter int  AXI_ADDR_WIDTH = 32,
  parameter int  RD_LAT         = 1,
  localparam int LSB            = $clog2(AXI_WIDTH) - 3,
  localparam int AW             = AXI_ADDR_WIDTH - LSB,
  localparam int SW             = AXI_WIDTH / 8,
  localparam int IDW            = id_width(NCH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req_valid,
  output logic [NCH-1:0]           req_ready,
  input  logic [NCH-1:0]           req_we,
  input  logic [NCH*AW-1:0]        req_addr,
  input  logic [NCH*AXI_WIDTH-1:0] req_wdata,
  input  logic [NCH*SW-1:0]        req_wstrb,
  output logic [NCH-1:0]           rsp_valid,
  output logic [AXI_WIDTH-1:0]     rsp_data,
  output logic                     ren,
  output logic [AW-1:0]            raddr,
  input  logic [AXI_WIDTH-1:0]     rdata,
  output logic                     wen,
  output logic [AW-1:0]            waddr,
  output logic [AXI_WIDTH-1:0]     wdata,
  output logic [SW-1:0]            wstrb
);

  logic [NCH-1:0] req_elig;
  logic [NCH-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;

  // No channel may be accepted while reset is held.
  assign req_elig = rst ? '0 : req_valid;

  rr_arbiter #(.NCH(NCH)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_elig),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .gnt_any_o (gnt_any)
  );

  assign req_ready = gnt;

  // One-hot select of the granted channel's payload.
  arb_req_t sel;
  always_comb begin
    sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) begin
        sel.we                   = req_we[i];
        sel.addr[AW-1:0]         = req_addr[i*AW +: AW];
        sel.wdata[AXI_WIDTH-1:0] = req_wdata[i*AXI_WIDTH +: AXI_WIDTH];
        sel.wstrb[SW-1:0]        = req_wstrb[i*SW +: SW];
      end
    end
  end

  // Upper struct bits are always zero for narrower configurations.
  logic unused_sel;
  assign unused_sel = ^sel;

  logic                 ren_q, wen_q;
  logic [AW-1:0]        raddr_q, waddr_q;
  logic [AXI_WIDTH-1:0] wdata_q;
  logic [SW-1:0]        wstrb_q;
  logic [IDW-1:0]       id_q;
  logic [RD_LAT-1:0]    tv_q;
  logic [IDW-1:0]       tag_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      id_q    <= '0;
      tv_q    <= '0;
      for (int j = 0; j < RD_LAT; j++) tag_q[j] <= '0;
    end else begin
      ren_q <= gnt_any & ~sel.we;
      wen_q <= gnt_any & sel.we;
      if (gnt_any) begin
        id_q <= gnt_id;
        if (sel.we) begin
          waddr_q <= sel.addr[AW-1:0];
          wdata_q <= sel.wdata[AXI_WIDTH-1:0];
          wstrb_q <= sel.wstrb[SW-1:0];
        end else begin
          raddr_q <= sel.addr[AW-1:0];
        end
      end
      // Tag pipeline: entry enters on the ren cycle, exits as rdata arrives.
      tv_q[0]  <= ren_q;
      tag_q[0] <= id_q;
      for (int j = 1; j < RD_LAT; j++) begin
        tv_q[j]  <= tv_q[j-1];
        tag_q[j] <= tag_q[j-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tv_q[RD_LAT-1]) rsp_valid[tag_q[RD_LAT-1]] = 1'b1;
  end

  assign rsp_data = rdata;
  assign ren      = ren_q;
  assign wen      = wen_q;
  assign raddr    = raddr_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign wstrb    = wstrb_q;

endmodule : ram_rr_arbiter
`default_nettype wire
